// File: rtl/regwrite_queue.sv
// regwrite_queue: write-back FIFO in front of the 32x32 register set. Two
// forwarding lookups report the youngest pending write for a register.
module regwrite_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_addr,
   input  logic [31:0] in_data,
   input  logic        wb_stall,
   output logic        regWrite,
   output logic [31:0] decOut,
   output logic [31:0] writeData,
   input  logic [4:0]  rd_addr_a,
   input  logic [4:0]  rd_addr_b,
   output logic        rd_hit_a,
   output logic        rd_hit_b,
   output logic [31:0] rd_data_a,
   output logic [31:0] rd_data_b
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [4:0]       memAddr [DEPTH];
   logic [31:0]      memData [DEPTH];
   logic [PTR_W-1:0] wrPtr, rdPtr, slot;
   logic [PTR_W:0]   count;
   logic             full, empty, push, pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign in_ready = !full && !reset;
   // Address 0 completes the handshake but is dropped: register 0 is never written.
   assign push     = in_valid && in_ready && (in_addr != 5'd0);
   assign regWrite = !empty && !wb_stall && !reset;
   assign pop      = regWrite;

   assign decOut    = regWrite ? (32'd1 << memAddr[rdPtr]) : '0;
   assign writeData = (!empty && !reset) ? memData[rdPtr] : '0;

   // NOTE: the entry array has no reset; occupancy alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         memAddr[wrPtr] <= in_addr;
         memData[wrPtr] <= in_data;
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Scan oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      rd_hit_a  = 1'b0;
      rd_hit_b  = 1'b0;
      rd_data_a = '0;
      rd_data_b = '0;
      slot      = rdPtr;
      for (int i = 0; i < DEPTH; i++) begin
         slot = rdPtr + PTR_W'(i);
         if (!reset && ((PTR_W+1)'(i) < count)) begin
            if (rd_addr_a != 5'd0 && memAddr[slot] == rd_addr_a) begin
               rd_hit_a  = 1'b1;
               rd_data_a = memData[slot];
            end
            if (rd_addr_b != 5'd0 && memAddr[slot] == rd_addr_b) begin
               rd_hit_b  = 1'b1;
               rd_data_b = memData[slot];
            end
         end
      end
   end

endmodule

// File: tb/tb_regwrite_queue.sv
// Self-checking bench for regwrite_queue: directed scenarios plus random
// traffic, all compared against a queue-based model of pending writes.
module tb_regwrite_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, wb_stall, regWrite;
   logic [4:0]  in_addr, rd_addr_a, rd_addr_b;
   logic [31:0] in_data, decOut, writeData, rd_data_a, rd_data_b;
   logic        rd_hit_a, rd_hit_b;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } entry_t;

   entry_t model[$];
   int total = 0;
   int bad = 0;

   regwrite_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
      .regWrite(regWrite), .decOut(decOut), .writeData(writeData),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_hit_a(rd_hit_a), .rd_hit_b(rd_hit_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Youngest pending write to a register: {hit, data}.
   function automatic logic [32:0] lookup(input logic [4:0] a);
      logic [32:0] r;
      r = '0;
      if (!reset && a != 5'd0)
         foreach (model[i])
            if (model[i].addr == a) r = {1'b1, model[i].data};
      return r;
   endfunction

   // Compare every output against the model mid-cycle, then advance the model over the edge.
   task automatic step();
      logic        expReady, expWr;
      logic [31:0] expDec, expData;
      logic [32:0] la, lb;
      entry_t      e;
      @(negedge clk);
      expReady = !reset && (model.size() < DEPTH);
      expWr    = !reset && (model.size() > 0) && !wb_stall;
      expDec   = '0;
      expData  = '0;
      if (!reset && model.size() > 0) begin
         expData = model[0].data;
         if (expWr) expDec = 32'd1 << model[0].addr;
      end
      la = lookup(rd_addr_a);
      lb = lookup(rd_addr_b);
      check("in_ready", in_ready, expReady);
      check("regWrite", regWrite, expWr);
      check("decOut", decOut, expDec);
      check("writeData", writeData, expData);
      check("rd_hit_a", rd_hit_a, la[32]);
      check("rd_data_a", rd_data_a, la[31:0]);
      check("rd_hit_b", rd_hit_b, lb[32]);
      check("rd_data_b", rd_data_b, lb[31:0]);
      if (reset) model.delete();
      else begin
         if (expWr) void'(model.pop_front());
         if (in_valid && expReady && in_addr != 5'd0) begin
            e.addr = in_addr;
            e.data = in_data;
            model.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic enqueue(input logic [4:0] a, input logic [31:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      logic accepted;
      reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
      wb_stall = 1'b0; rd_addr_a = 5'd5; rd_addr_b = 5'd0;
      @(posedge clk); #1;

      // Reset release
      step(); step();
      reset = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_regWrite", regWrite, 0);
      check("rst_decOut", decOut, 0);
      check("rst_hit_a", rd_hit_a, 0);
      step();

      // Single write
      enqueue(5'd3, 32'hDEADBEEF);
      #1;
      check("single_regWrite", regWrite, 1);
      check("single_decOut", decOut, 32'h0000_0008);
      check("single_data", writeData, 32'hDEADBEEF);
      step();
      check("single_idle", regWrite, 0);

      // Full and wrap
      wb_stall = 1'b1;
      for (int k = 1; k <= 4; k++) enqueue(5'(k), 32'(k * 'h11));
      #1;
      check("full_ready", in_ready, 0);
      in_valid = 1'b1; in_addr = 5'd5; in_data = 32'h55;
      step(); step();
      wb_stall = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("wrap_decOut", decOut, 32'h2 << k);
         accepted = in_valid && in_ready;
         step();
         if (accepted) in_valid = 1'b0;
      end
      step();

      // Forwarding priority
      wb_stall = 1'b1;
      rd_addr_a = 5'd7; rd_addr_b = 5'd0;
      enqueue(5'd7, 32'hA);
      enqueue(5'd7, 32'hB);
      #1;
      check("fwd_hit", rd_hit_a, 1);
      check("fwd_data", rd_data_a, 32'hB);
      check("fwd_zero_b", rd_hit_b, 0);
      wb_stall = 1'b0;
      step(); step(); step();
      check("fwd_drained", rd_hit_a, 0);

      // Address 0 discard
      in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFF_FFFF;
      #1;
      check("a0_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      #1;
      check("a0_regWrite", regWrite, 0);
      step();

      // Reset mid-operation
      wb_stall = 1'b1;
      enqueue(5'd9, 32'h99);
      enqueue(5'd10, 32'hAA);
      enqueue(5'd11, 32'hBB);
      reset = 1'b1;
      step();
      reset = 1'b0; wb_stall = 1'b0;
      for (int k = 9; k <= 11; k++) begin
         rd_addr_a = 5'(k); rd_addr_b = 5'(k);
         #1;
         check("rstmid_regWrite", regWrite, 0);
         check("rstmid_ready", in_ready, 1);
         check("rstmid_hit", rd_hit_a, 0);
         step();
      end

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 199) == 0);
         in_valid  = ($urandom_range(0, 99) < 60);
         in_addr   = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) in_addr = 5'($urandom_range(0, 31));
         in_data   = $urandom;
         wb_stall  = ($urandom_range(0, 99) < 35);
         rd_addr_a = 5'($urandom_range(0, 7));
         rd_addr_b = 5'($urandom_range(0, 7));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regwrite_queue.md
# regwrite_queue

Write-back buffer that sits directly upstream of the 32x32 register set. It accepts register-write requests from the write-back stage through a valid/ready handshake and queues them in a small FIFO. It drains one entry per cycle onto the register set's `regWrite` / `decOut` / `writeData` inputs. Two read-side lookup ports report the youngest still-pending write to a given register, so decode logic can forward data that has not yet landed.

## Interface

- `DEPTH`, default 4: number of queue entries; power of two, at least 2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: a write request is presented.
- `in_ready`, output, 1: the queue can accept a request this cycle.
- `in_addr`, input, 5: destination register number.
- `in_data`, input, 32: value to write.
- `wb_stall`, input, 1: the register-set port is unavailable this cycle; hold the head entry.
- `regWrite`, output, 1: a head entry is being written this cycle.
- `decOut`, output, 32: one-hot decode of the head address; all zeros when `regWrite` is 0.
- `writeData`, output, 32: head data; 0 when the queue is empty.
- `rd_addr_a`, `rd_addr_b`, input, 5: lookup addresses.
- `rd_hit_a`, `rd_hit_b`, output, 1: a pending entry matches the lookup address.
- `rd_data_a`, `rd_data_b`, output, 32: data of the youngest matching entry; 0 on a miss.

## Operation

- **Storage and pointers**
  - Circular buffer of `DEPTH` entries, each holding a 5-bit address and 32-bit data.
  - Write pointer, read pointer and occupancy count, each sized for `DEPTH`. Pointers wrap modulo `DEPTH`.
- **Enqueue**
  - Occurs when `in_valid && in_ready`.
  - `in_ready = !full && !reset`. `in_ready` has no combinational dependence on `wb_stall` or on a same-cycle pop.
  - A full queue refuses input even if the head drains that cycle.
- **Address 0**
  - A request with `in_addr == 0` is accepted (handshake completes) and discarded.
  - It is not queued, does not change occupancy, and never hits a lookup.
- **Dequeue**
  - `regWrite = !empty && !wb_stall`. When `regWrite` is 1, the register set captures the head and the read pointer advances on the same edge.
  - `decOut`: bit `head_addr` is set when `regWrite` is 1; all zeros otherwise.
  - `writeData = head data` whenever the queue is not empty.
- **Simultaneous enqueue and dequeue (not full)**
  - Occupancy is unchanged and both pointers advance.
  - With exactly one entry present, the new entry becomes head on the next cycle.
- **Write ordering**
  - Writes drain in strict acceptance order, so the last write to a register wins.
- **Lookup**
  - Purely combinational over the valid entries.
  - A hit requires the address to match and be nonzero. Priority goes to the youngest entry, i.e. the one closest behind the write pointer.
  - An entry being popped this cycle is still visible.
  - A request being enqueued this cycle is not yet visible.
- **Reset**
  - `reset` high at an edge clears the pointers and the count. All pending entries are dropped and never written, including mid-drain.
  - While `reset` is high: `in_ready`=0, `regWrite`=0, `decOut`=0, `writeData`=0, hits 0, lookup data 0.
- The entry storage array itself needs no reset.

## Timing

- **Latency**
  - A request accepted at edge N appears as head after edge N (if the queue was empty) and drives `regWrite` in cycle N+1.
  - It lands in the register set at edge N+1 when `wb_stall` is low.
  - Minimum accept-to-architected latency is 1 cycle plus the register set's capture edge.
- **Throughput**
  - One enqueue and one dequeue per cycle, sustained, with no bubbles when `wb_stall` is low.
- **Full and empty**
  - Full: `in_ready` drops in the cycle the count reaches `DEPTH` and rises in the cycle after the first pop.
  - Empty: `regWrite` stays 0 regardless of `wb_stall`.
- **Stall**
  - `wb_stall` high holds `regWrite`, `decOut` and the read pointer.
  - The head entry and its outputs stay stable for every stalled cycle.
- Lookup outputs are combinational from the current-cycle state and `rd_addr_*`.

## Test plan

- **Reset release:** hold `reset` 2 cycles then release.
  - Required: `in_ready`=1, `regWrite`=0, `decOut`=0, `rd_hit_a`=0 for `rd_addr_a`=5.
- **Single write:** enqueue addr 3, data 0xDEADBEEF; `wb_stall`=0.
  - Next cycle: `regWrite`=1, `decOut`=0x00000008, `writeData`=0xDEADBEEF.
  - Cycle after: `regWrite`=0.
- **Full and wrap:** `DEPTH`=4, `wb_stall`=1, enqueue addrs 1,2,3,4 with data 0x11..0x44.
  - `in_ready`=0 after the 4th.
  - A 5th request (addr 5) is held until drained.
  - Release the stall: `decOut` sequence 0x2, 0x4, 0x8, 0x10, 0x20 on consecutive cycles; pointers wrap correctly.
- **Forwarding priority:** stall, enqueue addr 7 data 0xA then addr 7 data 0xB; `rd_addr_a`=7.
  - Required: `rd_hit_a`=1, `rd_data_a`=0xB.
  - After both entries drain: `rd_hit_a`=0.
  - `rd_addr_b`=0 never hits.
- **Address 0 discard:** enqueue addr 0 data 0xFFFFFFFF.
  - Required: handshake completes, occupancy stays 0, `regWrite` stays 0.
- **Reset mid-operation:** stall with 3 entries queued, pulse `reset` for 1 cycle, then clear the stall.
  - Required: no `regWrite` pulse ever occurs.
  - `in_ready`=1 and lookups miss for all 3 addresses.
